// File: rtl/jam_cost_rom.sv
// Cost table responder for the job-assignment engine: streamed 8x8 table load,
// registered (W, J) lookup, and one-shot capture of the engine's final result.
module jam_cost_rom #(
  parameter int unsigned COST_W = 7,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [COST_W-1:0] LoadData,
  output logic              LoadReady,
  output logic              TableReady,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic              ResDone,
  output logic [9:0]        ResMinCost,
  output logic [3:0]        ResMatchCount
);

  localparam int unsigned PtrW  = 2 * IDX_W;
  localparam int unsigned Depth = 1 << PtrW;

  typedef enum logic [1:0] {StIdle, StLoad, StServe} state_e;

  state_e            state;
  logic [PtrW-1:0]   ptr;
  logic [COST_W-1:0] mem [Depth];
  logic              load_accept;

  // A coincident LoadStart wins: that beat is dropped, not written.
  assign load_accept = (state == StLoad) && LoadValid && LoadReady && !LoadStart;

  // Table storage survives reset and reloads; TableReady gates its use.
  always_ff @(posedge CLK) begin
    if (load_accept) begin
      mem[ptr] <= LoadData;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= StIdle;
      ptr           <= '0;
      LoadReady     <= 1'b0;
      TableReady    <= 1'b0;
      Cost          <= '0;
      ResDone       <= 1'b0;
      ResMinCost    <= '0;
      ResMatchCount <= '0;
    end else if (LoadStart) begin
      state      <= StLoad;
      ptr        <= '0;
      LoadReady  <= 1'b1;
      TableReady <= 1'b0;
      ResDone    <= 1'b0;
      Cost       <= '0;
    end else begin
      case (state)
        StIdle: begin
          Cost <= '0;
        end
        StLoad: begin
          Cost <= '0;
          if (load_accept) begin
            ptr <= ptr + 1'b1;
            if (&ptr) begin
              state      <= StServe;
              LoadReady  <= 1'b0;
              TableReady <= 1'b1;
            end
          end
        end
        StServe: begin
          Cost <= mem[{W, J}];
          // An X/Z Valid takes the else path in simulation, so only 1'b1 captures.
          if (Valid && !ResDone) begin
            ResDone       <= 1'b1;
            ResMinCost    <= MinCost;
            ResMatchCount <= MatchCount;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
